pipe_hazard_ctrl: RTL
=====================

Name: pipe_hazard_ctrl

Overview:
Central pipeline control unit for the 5-stage RV32I core. It drives the fetch stage's next-PC select (npc_control/branch_pc) and PC hold, and generates IF/ID, ID/EX and EX/MEM stall and flush strobes for load-use hazards and taken branches/jumps resolved in MEM. It runs a halt-drain FSM so an invalid-opcode halt from fetch retires older instructions before the core stops. It also keeps saturating stall/flush performance counters.

Parameters:
REG_AW, 5, register address width
DRAIN_CYCLES, 4, cycles spent in DRAIN before halting; legal range 1..15
CNT_W, 32, performance counter width

Ports:
clk  in  1  clock; all state updates on posedge
rst  in  1  reset, synchronous, active-low
if_halt  in  1  fetch decoded a non-RV32I opcode
id_rs1  in  REG_AW  ID-stage source register 1
id_rs2  in  REG_AW  ID-stage source register 2
id_use_rs1  in  1  ID instruction reads rs1
id_use_rs2  in  1  ID instruction reads rs2
ex_rd  in  REG_AW  EX-stage destination register
ex_is_load  in  1  EX instruction is a load
mem_taken  in  1  MEM resolved a taken branch or jump
mem_target  in  32  redirect target from MEM
npc_control  out  1  fetch selects branch_pc
branch_pc  out  32  redirect PC to fetch
pc_stall  out  1  hold PC
ifid_stall  out  1  hold IF/ID register
ifid_flush  out  1  bubble IF/ID
idex_flush  out  1  bubble ID/EX
exmem_flush  out  1  bubble EX/MEM
halt  out  1  core halted (sticky)
state  out  2  FSM state: RUN=0, DRAIN=1, HALTED=2
stall_cnt  out  CNT_W  load-use stall cycles
flush_cnt  out  CNT_W  redirect events

Behaviour:
- Reset (rst==0 at posedge): state=RUN, drain counter=0, halt=0, stall_cnt=0, flush_cnt=0. Strobes are combinational from state and inputs. With rst==0 all strobes and npc_control are forced to 0, and branch_pc=0. Reset mid-DRAIN or in HALTED returns to RUN on the next edge.
- Load-use hazard: lu = ex_is_load & (ex_rd!=0) & ((id_use_rs1 & id_rs1==ex_rd) | (id_use_rs2 & id_rs2==ex_rd)).
- Redirect priority 1, in any state except HALTED. When mem_taken=1, same cycle, with zero latency:
  - npc_control=1, branch_pc=mem_target.
  - ifid_flush=idex_flush=exmem_flush=1.
  - pc_stall=ifid_stall=0.
  - flush_cnt increments at the edge.
  - If in DRAIN, the halt was wrong-path: next state is RUN and the drain counter clears.
  - if_halt in the same cycle is ignored.
- Load-use priority 2, RUN only, when lu & !mem_taken:
  - pc_stall=1, ifid_stall=1, idex_flush=1.
  - stall_cnt increments.
  - if_halt in the same cycle is ignored, because the instruction is re-fetched.
- Halt entry priority 3, RUN only: if_halt & !mem_taken & !lu moves to DRAIN and loads the drain counter with DRAIN_CYCLES-1. From that cycle on, pc_stall=1 and ifid_flush=1.
- DRAIN: pc_stall=1 and ifid_flush=1 every cycle. The counter decrements each cycle. If the counter==0 and !mem_taken, move to HALTED. Load-use is not evaluated in DRAIN, because only older instructions are in flight.
- HALTED: pc_stall=1, ifid_flush=1 and halt=1, held until reset. mem_taken is ignored.
- npc_control=0 and branch_pc=0 whenever mem_taken=0.
- Counters saturate at all-ones and do not wrap.
- state output equals the internal FSM register.

Decomposition:
- Shared package/header: state encodings RUN/DRAIN/HALTED, and REG_AW if not already defined.
- Opcode defines remain in the existing shared defines.
- One natural sub-module: sat_counter (CNT_W, inc, rst), instantiated twice.

Test Plan:
- Reset: hold rst=0 for 2 cycles, then release. All outputs 0, state=0 and counters 0 for the cycle after release.
- Load-use: ex_is_load=1, ex_rd=5, id_rs2=5, id_use_rs2=1 for one cycle. pc_stall=ifid_stall=idex_flush=1 that cycle, and stall_cnt=1. Repeat with ex_rd=0: no stall.
- Redirect: mem_taken=1, mem_target=0x0000_0040, with lu also true. npc_control=1, branch_pc=0x40, three flushes=1, pc_stall=0, flush_cnt=1, stall_cnt unchanged.
- Halt drain: pulse if_halt with DRAIN_CYCLES=4. state=DRAIN for exactly 4 cycles, then HALTED with halt=1. Halt persists despite a later mem_taken=1 and npc_control stays 0.
- Wrong-path halt: if_halt, then mem_taken=1 two cycles into DRAIN. state returns to RUN, halt never asserts, npc_control=1 that cycle.
- Simultaneous events and saturation: if_halt together with mem_taken stays in RUN. Force stall_cnt to near max using CNT_W=4 and 17 stall cycles; stall_cnt holds at 15.

Source files
------------

// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard/redirect/halt controller.
// State encodings are fixed because they are exported on the state port.
package pipe_hazard_ctrl_pkg;

    localparam int DEFAULT_REG_AW = 5;
    localparam int DRAIN_CNT_W    = 4;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_HALTED = 2'd2
    } state_e;

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Bundle between the pipeline stages (master) and the hazard controller (slave).
import pipe_hazard_ctrl_pkg::*;

interface pipe_hazard_ctrl_if #(
    parameter int REG_AW = DEFAULT_REG_AW,
    parameter int CNT_W  = 32
);
    logic              if_halt;
    logic [REG_AW-1:0] id_rs1;
    logic [REG_AW-1:0] id_rs2;
    logic              id_use_rs1;
    logic              id_use_rs2;
    logic [REG_AW-1:0] ex_rd;
    logic              ex_is_load;
    logic              mem_taken;
    logic [31:0]       mem_target;

    logic              npc_control;
    logic [31:0]       branch_pc;
    logic              pc_stall;
    logic              ifid_stall;
    logic              ifid_flush;
    logic              idex_flush;
    logic              exmem_flush;
    logic              halt;
    logic [1:0]        state;
    logic [CNT_W-1:0]  stall_cnt;
    logic [CNT_W-1:0]  flush_cnt;

    modport master (
        output if_halt, id_rs1, id_rs2, id_use_rs1, id_use_rs2,
               ex_rd, ex_is_load, mem_taken, mem_target,
        input  npc_control, branch_pc, pc_stall, ifid_stall, ifid_flush,
               idex_flush, exmem_flush, halt, state, stall_cnt, flush_cnt
    );

    modport slave (
        input  if_halt, id_rs1, id_rs2, id_use_rs1, id_use_rs2,
               ex_rd, ex_is_load, mem_taken, mem_target,
        output npc_control, branch_pc, pc_stall, ifid_stall, ifid_flush,
               idex_flush, exmem_flush, halt, state, stall_cnt, flush_cnt
    );

endinterface

// File: rtl/pipe_hazard_ctrl_sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc_i,
    output logic [CNT_W-1:0] cnt_o
);

    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q <= '0;
        end else if (inc_i && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline control: MEM redirects, load-use stalls, halt drain FSM and perf counters.
// Redirect beats load-use beats halt entry; HALTED ignores everything but reset.
import pipe_hazard_ctrl_pkg::*;

module pipe_hazard_ctrl #(
    parameter int REG_AW       = DEFAULT_REG_AW,
    parameter int DRAIN_CYCLES = 4,
    parameter int CNT_W        = 32
) (
    input logic               clk,
    input logic               rst,
    pipe_hazard_ctrl_if.slave bus
);

    state_e                 state_q, state_d;
    logic [DRAIN_CNT_W-1:0] drainCnt_q, drainCnt_d;

    logic        loadUse;
    logic        stallInc;
    logic        flushInc;
    logic        npcControl;
    logic [31:0] branchPc;
    logic        pcStall;
    logic        ifidStall;
    logic        ifidFlush;
    logic        idexFlush;
    logic        exmemFlush;

    assign loadUse = bus.ex_is_load && (bus.ex_rd != {REG_AW{1'b0}}) &&
                     ((bus.id_use_rs1 && (bus.id_rs1 == bus.ex_rd)) ||
                      (bus.id_use_rs2 && (bus.id_rs2 == bus.ex_rd)));

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= ST_RUN;
            drainCnt_q <= '0;
        end else begin
            state_q    <= state_d;
            drainCnt_q <= drainCnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        drainCnt_d = drainCnt_q;
        stallInc   = 1'b0;
        flushInc   = 1'b0;
        npcControl = 1'b0;
        branchPc   = 32'd0;
        pcStall    = 1'b0;
        ifidStall  = 1'b0;
        ifidFlush  = 1'b0;
        idexFlush  = 1'b0;
        exmemFlush = 1'b0;

        unique case (state_q)
            ST_RUN: begin
                if (bus.mem_taken) begin
                    npcControl = 1'b1;
                    branchPc   = bus.mem_target;
                    ifidFlush  = 1'b1;
                    idexFlush  = 1'b1;
                    exmemFlush = 1'b1;
                    flushInc   = 1'b1;
                end else if (loadUse) begin
                    pcStall   = 1'b1;
                    ifidStall = 1'b1;
                    idexFlush = 1'b1;
                    stallInc  = 1'b1;
                end else if (bus.if_halt) begin
                    pcStall    = 1'b1;
                    ifidFlush  = 1'b1;
                    state_d    = ST_DRAIN;
                    drainCnt_d = DRAIN_CNT_W'(DRAIN_CYCLES - 1);
                end
            end
            ST_DRAIN: begin
                // A redirect here means the halting fetch was on the wrong path.
                if (bus.mem_taken) begin
                    npcControl = 1'b1;
                    branchPc   = bus.mem_target;
                    ifidFlush  = 1'b1;
                    idexFlush  = 1'b1;
                    exmemFlush = 1'b1;
                    flushInc   = 1'b1;
                    state_d    = ST_RUN;
                    drainCnt_d = '0;
                end else begin
                    pcStall   = 1'b1;
                    ifidFlush = 1'b1;
                    if (drainCnt_q == '0) begin
                        state_d = ST_HALTED;
                    end else begin
                        drainCnt_d = drainCnt_q - 1'b1;
                    end
                end
            end
            ST_HALTED: begin
                pcStall   = 1'b1;
                ifidFlush = 1'b1;
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase

        if (!rst) begin
            stallInc   = 1'b0;
            flushInc   = 1'b0;
            npcControl = 1'b0;
            branchPc   = 32'd0;
            pcStall    = 1'b0;
            ifidStall  = 1'b0;
            ifidFlush  = 1'b0;
            idexFlush  = 1'b0;
            exmemFlush = 1'b0;
        end
    end

    assign bus.npc_control = npcControl;
    assign bus.branch_pc   = branchPc;
    assign bus.pc_stall    = pcStall;
    assign bus.ifid_stall  = ifidStall;
    assign bus.ifid_flush  = ifidFlush;
    assign bus.idex_flush  = idexFlush;
    assign bus.exmem_flush = exmemFlush;
    assign bus.halt        = (state_q == ST_HALTED) && rst;
    assign bus.state       = state_q;

    sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc_i (stallInc),
        .cnt_o (bus.stall_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc_i (flushInc),
        .cnt_o (bus.flush_cnt)
    );

endmodule
